fb_arbiter: RTL



---
 rtl/fb_arbiter_if.sv | 38 +++
 rtl/fb_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_arbiter_if
// Description : Scanout, PPU-write, clear and RAM signals of the framebuffer
//               arbiter. The arbiter takes the slave modport, its environment
//               the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 15
);
    logic [11:0]   rd_x;
    logic [11:0]   rd_y;
    logic [DW-1:0] rd_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [7:0]    wr_x;
    logic [7:0]    wr_y;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          clear_req;
    logic          clear_busy;

    modport master (
        output rd_x, rd_y, wr_valid, wr_x, wr_y, wr_data, mem_rdata, clear_req,
        input  rd_data, wr_ready, mem_addr, mem_we, mem_wdata, clear_busy
    );

    modport slave (
        input  rd_x, rd_y, wr_valid, wr_x, wr_y, wr_data, mem_rdata, clear_req,
        output rd_data, wr_ready, mem_addr, mem_we, mem_wdata, clear_busy
    );
endinterface
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_arbiter
// Description : Single-port framebuffer arbiter. Scanout reads win; PPU writes
//               are queued and drained in free slots. Optional clear
//               sequencer enabled by the FB_CLEAR_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 144,
    parameter int DW          = 8,
    parameter int AW          = $clog2(WIDTH*HEIGHT),
    parameter int FIFO_DEPTH  = 4,
    parameter int CLEAR_VALUE = 0
) (
    input  wire logic   clock25mhz,
    input  wire logic   resetn,
    fb_arbiter_if.slave bus
);
    localparam int            c_PW       = $clog2(FIFO_DEPTH);
    localparam int            c_CW       = c_PW + 1;
    localparam logic [AW-1:0] c_PIX_LAST = AW'(WIDTH*HEIGHT - 1);
    localparam logic [DW-1:0] c_CLEAR    = DW'(CLEAR_VALUE);

    logic          w_rd_in_range;
    logic          w_rd_slot;
    logic          w_free;
    logic [AW-1:0] w_ra;
    logic          r_last_valid;
    logic [AW-1:0] r_last_addr;
    logic          r_rd_p1;
    logic          r_rd_p2;
    logic [DW-1:0] r_rd_data;

    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_wdata;

    logic [7:0]    r_fx [FIFO_DEPTH];
    logic [7:0]    r_fy [FIFO_DEPTH];
    logic [DW-1:0] r_fd [FIFO_DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_hx;
    logic [7:0]    w_hy;
    logic [DW-1:0] w_hd;
    logic          w_h_in_range;
    logic [AW-1:0] w_wa;

    logic          w_clearing;
    logic          w_clr_write;
    logic [AW-1:0] w_clr_addr;

    assign w_rd_in_range = (bus.rd_x < 12'(WIDTH)) && (bus.rd_y < 12'(HEIGHT));
    assign w_ra          = AW'(bus.rd_y) * AW'(WIDTH) + AW'(bus.rd_x);
    assign w_rd_slot     = w_rd_in_range && (!r_last_valid || (w_ra != r_last_addr));
    assign w_free        = !w_rd_slot;

    assign w_full   = (r_count == c_CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = bus.wr_valid && !w_full;
    assign w_pop    = w_free && !w_clearing && !w_empty;
    assign w_hx     = r_fx[r_rptr];
    assign w_hy     = r_fy[r_rptr];
    assign w_hd     = r_fd[r_rptr];
    // Off-screen PPU writes still pop so the queue never stalls on them.
    assign w_h_in_range = ({4'd0, w_hx} < 12'(WIDTH)) && ({4'd0, w_hy} < 12'(HEIGHT));
    assign w_wa     = AW'(w_hy) * AW'(WIDTH) + AW'(w_hx);

`ifdef FB_CLEAR_EN
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_CLEAR = 1'b1;

    logic [0:0]    r_state;
    logic [AW-1:0] r_clr_cnt;
    logic          r_clear_busy;

    assign w_clearing  = (r_state == c_CLEAR);
    assign w_clr_write = w_clearing && w_free;
    assign w_clr_addr  = r_clr_cnt;

    always_ff @(posedge clock25mhz or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_clr_cnt    <= '0;
            r_clear_busy <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.clear_req) begin
                        r_state      <= c_CLEAR;
                        r_clr_cnt    <= '0;
                        r_clear_busy <= 1'b1;
                    end
                end
                c_CLEAR: begin
                    if (w_free) begin
                        if (r_clr_cnt == c_PIX_LAST) begin
                            r_state      <= c_IDLE;
                            r_clear_busy <= 1'b0;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.clear_busy = r_clear_busy;
`else
    logic unused_clear_req;

    assign unused_clear_req = bus.clear_req;
    assign w_clearing       = 1'b0;
    assign w_clr_write      = 1'b0;
    assign w_clr_addr       = '0;
    assign bus.clear_busy   = 1'b0;
`endif

    always_ff @(posedge clock25mhz) begin
        if (w_push) begin
            r_fx[r_wptr] <= bus.wr_x;
            r_fy[r_wptr] <= bus.wr_y;
            r_fd[r_wptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock25mhz or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Address pipeline: read beats clear, clear beats queued writes.
    always_ff @(posedge clock25mhz or negedge resetn) begin
        if (!resetn) begin
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_last_valid <= 1'b0;
            r_last_addr  <= '0;
            r_rd_p1      <= 1'b0;
            r_rd_p2      <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_rd_slot) begin
                r_mem_addr   <= w_ra;
                r_last_valid <= 1'b1;
                r_last_addr  <= w_ra;
            end else if (w_clr_write) begin
                r_mem_addr  <= w_clr_addr;
                r_mem_wdata <= c_CLEAR;
                r_mem_we    <= 1'b1;
            end else if (w_pop && w_h_in_range) begin
                r_mem_addr  <= w_wa;
                r_mem_wdata <= w_hd;
                r_mem_we    <= 1'b1;
            end
            r_rd_p1 <= w_rd_slot;
            r_rd_p2 <= r_rd_p1;
            if (r_rd_p2) r_rd_data <= bus.mem_rdata;
        end
    end

    assign bus.wr_ready  = !w_full;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.rd_data   = r_rd_data;
endmodule
`default_nettype wire
